// File: rtl/cp0_regfile_v2_pkg.sv
// Shared definitions for the CP0 register file: {rd,sel} addresses,
// Status/Cause field positions, write masks and exception vector constants.
package cp0_regfile_v2_pkg;

  // CP0 register addresses, encoded as {rd[4:0], sel[2:0]}
  localparam logic [7:0] ADDR_INDEX    = 8'h00;
  localparam logic [7:0] ADDR_RANDOM   = 8'h08;
  localparam logic [7:0] ADDR_ENTRYLO0 = 8'h10;
  localparam logic [7:0] ADDR_ENTRYLO1 = 8'h18;
  localparam logic [7:0] ADDR_WIRED    = 8'h30;
  localparam logic [7:0] ADDR_BADVADDR = 8'h40;
  localparam logic [7:0] ADDR_COUNT    = 8'h48;
  localparam logic [7:0] ADDR_ENTRYHI  = 8'h50;
  localparam logic [7:0] ADDR_COMPARE  = 8'h58;
  localparam logic [7:0] ADDR_STATUS   = 8'h60;
  localparam logic [7:0] ADDR_CAUSE    = 8'h68;
  localparam logic [7:0] ADDR_EPC      = 8'h70;
  localparam logic [7:0] ADDR_PRID     = 8'h78;
  localparam logic [7:0] ADDR_CONFIG   = 8'h80;

  // Status field positions
  localparam int STATUS_IE    = 0;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_ERL   = 2;
  localparam int STATUS_UM    = 4;
  localparam int STATUS_IM_LO = 8;
  localparam int STATUS_IM_HI = 15;
  localparam int STATUS_BEV   = 22;
  localparam int STATUS_CU0   = 28;

  // Cause field positions
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 8;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_IV     = 23;
  localparam int CAUSE_TI     = 30;
  localparam int CAUSE_BD     = 31;

  // Software-writable bits and reset images
  localparam logic [31:0] STATUS_WMASK    = 32'h1040_FF17;
  localparam logic [31:0] STATUS_RESET    = 32'h0040_0002;
  localparam logic [31:0] STATUS_EXL_MASK = 32'h0000_0002;
  localparam logic [31:0] ENTRYHI_WMASK   = 32'hFFFF_E0FF;
  localparam logic [31:0] ENTRYLO_WMASK   = 32'h03FF_FFFF;

  // Config images: M=1, K0=2, MT=1 only when the TLB registers exist
  localparam logic [31:0] CONFIG_TLB    = 32'h8000_0082;
  localparam logic [31:0] CONFIG_NO_TLB = 32'h8000_0002;

  // Exception vector bases and offsets
  localparam logic [31:0] VEC_BASE_BEV    = 32'hBFC0_0200;
  localparam logic [31:0] VEC_BASE_NORMAL = 32'h8000_0000;
  localparam logic [31:0] VEC_OFF_REFILL  = 32'h0000_0000;
  localparam logic [31:0] VEC_OFF_GENERAL = 32'h0000_0180;
  localparam logic [31:0] VEC_OFF_INT     = 32'h0000_0200;

  // Merge a software write into a register, touching only the masked bits
  function automatic logic [31:0] merge_write(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [31:0] wmask);
    return (old_val & ~wmask) | (wdata & wmask);
  endfunction

endpackage

// File: rtl/cp0_regfile_v2_timer.sv
// Count/Compare timer: prescaled free-running Count, Compare match and the
// sticky timer interrupt flag TI (cleared by any Compare write).
module cp0_timer
  import cp0_regfile_v2_pkg::*;
#(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam int PRE_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(COUNT_DIV - 1);

  logic [PRE_W-1:0] pre_r;
  logic [31:0]      count_r;
  logic [31:0]      compare_r;
  logic             ti_r;
  logic             pre_wrap_s;

  assign pre_wrap_s = (pre_r == PRE_LAST);

  // Prescaler and Count: a Count write restarts the prescale period
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_r   <= {PRE_W{1'b0}};
      count_r <= 32'h0;
    end else if (count_we) begin
      pre_r   <= {PRE_W{1'b0}};
      count_r <= wdata;
    end else if (pre_wrap_s) begin
      pre_r   <= {PRE_W{1'b0}};
      count_r <= count_r + 32'd1;
    end else begin
      pre_r   <= pre_r + PRE_W'(1);
      count_r <= count_r;
    end
  end

  // Compare register and sticky TI; a Compare write beats a same-cycle match
  always_ff @(posedge clk) begin
    if (reset) begin
      compare_r <= 32'h0;
      ti_r      <= 1'b0;
    end else if (compare_we) begin
      compare_r <= wdata;
      ti_r      <= 1'b0;
    end else if (count_r == compare_r) begin
      compare_r <= compare_r;
      ti_r      <= 1'b1;
    end else begin
      compare_r <= compare_r;
      ti_r      <= ti_r;
    end
  end

  assign count   = count_r;
  assign compare = compare_r;
  assign ti      = ti_r;

endmodule

// File: rtl/cp0_regfile_v2.sv
// CP0 register file with configurable interrupt lines, Count prescaler and
// TLB depth. Define CP0_TLB_REGS_EN to include Index/Random/Wired/EntryHi/
// EntryLo0/EntryLo1 and the TLBP/TLBR/refill paths; without it those
// registers read 0 and their inputs are ignored.
module cp0_regfile_v2
  import cp0_regfile_v2_pkg::*;
#(
  parameter int          NUM_HW_INT  = 6,
  parameter int          COUNT_DIV   = 2,
  parameter int          TLB_ENTRIES = 16,
  parameter logic [31:0] PRID        = 32'h0000_4220,
  localparam int         IDX_W       = $clog2(TLB_ENTRIES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_HW_INT-1:0] hw_int,
  output logic                  int_sig,
  input  logic                  mtc0,
  input  logic [31:0]           mtc0_data,
  input  logic [7:0]            addr,
  output logic [31:0]           mfc0_data,
  input  logic                  commit_exc,
  input  logic                  commit_eret,
  input  logic [4:0]            commit_code,
  input  logic                  commit_bd,
  input  logic [31:0]           commit_epc,
  input  logic [31:0]           commit_bvaddr,
  input  logic                  commit_tlb,
  input  logic                  commit_refill,
  input  logic                  tlbp_we,
  input  logic                  tlbp_hit,
  input  logic [IDX_W-1:0]      tlbp_index,
  input  logic                  tlbr_we,
  input  logic [31:0]           tlbr_entryhi,
  input  logic [31:0]           tlbr_entrylo0,
  input  logic [31:0]           tlbr_entrylo1,
  output logic [31:0]           exc_vector,
  output logic [31:0]           status,
  output logic [31:0]           cause,
  output logic [31:0]           epc,
  output logic [31:0]           entryhi,
  output logic [31:0]           entrylo0,
  output logic [31:0]           entrylo1,
  output logic [IDX_W-1:0]      index,
  output logic [IDX_W-1:0]      random
);

  // Commit and write decode
  logic exc_s;
  logic eret_s;
  logic wr_status_s;
  logic wr_cause_s;
  logic wr_epc_s;
  logic wr_count_s;
  logic wr_compare_s;

  assign exc_s        = commit_exc & ~commit_eret;
  assign eret_s       = commit_exc & commit_eret;
  assign wr_status_s  = mtc0 & (addr == ADDR_STATUS);
  assign wr_cause_s   = mtc0 & (addr == ADDR_CAUSE);
  assign wr_epc_s     = mtc0 & (addr == ADDR_EPC);
  assign wr_count_s   = mtc0 & (addr == ADDR_COUNT);
  assign wr_compare_s = mtc0 & (addr == ADDR_COMPARE);

  // Architectural state
  logic [31:0] status_r;
  logic        bd_r;
  logic [4:0]  exc_code_r;
  logic        iv_r;
  logic [1:0]  ip_sw_r;
  logic [5:0]  ip_hw_r;
  logic [31:0] epc_r;
  logic [31:0] badvaddr_r;
  logic [5:0]  hw_ext_s;
  logic [7:0]  ip_s;
  logic [31:0] cause_s;
  logic [31:0] count_s;
  logic [31:0] compare_s;
  logic        ti_s;

  // TLB register read views (zero when the TLB registers are absent)
  logic [31:0] index_rd_s;
  logic [31:0] random_rd_s;
  logic [31:0] wired_rd_s;
  logic [31:0] entryhi_rd_s;
  logic [31:0] entrylo0_rd_s;
  logic [31:0] entrylo1_rd_s;
  logic [31:0] config_val_s;
  logic        refill_s;

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (wr_count_s),
    .compare_we (wr_compare_s),
    .wdata      (mtc0_data),
    .count      (count_s),
    .compare    (compare_s),
    .ti         (ti_s)
  );

  // Zero-extend the external interrupt lines to the six hardware IP bits
  always_comb begin
    hw_ext_s = 6'b0;
    hw_ext_s[NUM_HW_INT-1:0] = hw_int;
  end

  // Status: exception sets EXL, ERET clears it, either drops a same-cycle mtc0
  always_ff @(posedge clk) begin
    if (reset) begin
      status_r <= STATUS_RESET;
    end else if (exc_s) begin
      status_r <= status_r | STATUS_EXL_MASK;
    end else if (eret_s) begin
      status_r <= status_r & ~STATUS_EXL_MASK;
    end else if (wr_status_s) begin
      status_r <= merge_write(status_r, mtc0_data, STATUS_WMASK);
    end else begin
      status_r <= status_r;
    end
  end

  // Cause BD/ExcCode: loaded only by an exception commit
  always_ff @(posedge clk) begin
    if (reset) begin
      bd_r       <= 1'b0;
      exc_code_r <= 5'd0;
    end else if (exc_s) begin
      bd_r       <= commit_bd;
      exc_code_r <= commit_code;
    end else begin
      bd_r       <= bd_r;
      exc_code_r <= exc_code_r;
    end
  end

  // Cause IV/IP1_0: software writable, blocked by a same-cycle exception commit
  always_ff @(posedge clk) begin
    if (reset) begin
      iv_r    <= 1'b0;
      ip_sw_r <= 2'b00;
    end else if (exc_s) begin
      iv_r    <= iv_r;
      ip_sw_r <= ip_sw_r;
    end else if (wr_cause_s) begin
      iv_r    <= mtc0_data[CAUSE_IV];
      ip_sw_r <= mtc0_data[CAUSE_IP_LO+1:CAUSE_IP_LO];
    end else begin
      iv_r    <= iv_r;
      ip_sw_r <= ip_sw_r;
    end
  end

  // Cause IP7..IP2: sample the hardware interrupt lines every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      ip_hw_r <= 6'b0;
    end else begin
      ip_hw_r <= hw_ext_s;
    end
  end

  // EPC and BadVAddr: exception commit wins over a software EPC write
  always_ff @(posedge clk) begin
    if (reset) begin
      epc_r      <= 32'h0;
      badvaddr_r <= 32'h0;
    end else if (exc_s) begin
      epc_r      <= commit_epc;
      badvaddr_r <= commit_bvaddr;
    end else if (wr_epc_s) begin
      epc_r      <= mtc0_data;
      badvaddr_r <= badvaddr_r;
    end else begin
      epc_r      <= epc_r;
      badvaddr_r <= badvaddr_r;
    end
  end

  // Timer interrupt shares IP7 with the highest hardware line
  assign ip_s    = {ip_hw_r[5] | ti_s, ip_hw_r[4:0], ip_sw_r};
  assign cause_s = {bd_r, ti_s, 6'b0, iv_r, 7'b0, ip_s, 1'b0, exc_code_r, 2'b00};

`ifdef CP0_TLB_REGS_EN
  localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(TLB_ENTRIES - 1);

  logic             wr_index_s;
  logic             wr_wired_s;
  logic             wr_entryhi_s;
  logic             wr_entrylo0_s;
  logic             wr_entrylo1_s;
  logic             idx_p_r;
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W-1:0] wired_r;
  logic [IDX_W-1:0] random_r;
  logic [18:0]      vpn2_r;
  logic [7:0]       asid_r;
  logic [25:0]      lo0_r;
  logic [25:0]      lo1_r;
  logic             unused_tlb_s;

  assign wr_index_s    = mtc0 & (addr == ADDR_INDEX);
  assign wr_wired_s    = mtc0 & (addr == ADDR_WIRED);
  assign wr_entryhi_s  = mtc0 & (addr == ADDR_ENTRYHI);
  assign wr_entrylo0_s = mtc0 & (addr == ADDR_ENTRYLO0);
  assign wr_entrylo1_s = mtc0 & (addr == ADDR_ENTRYLO1);
  assign unused_tlb_s  = ^{tlbr_entryhi[12:8], tlbr_entrylo0[31:26], tlbr_entrylo1[31:26]};

  // Index: TLBP sets the probe-fail bit and, on a hit, the matching index
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_p_r <= 1'b0;
      idx_r   <= {IDX_W{1'b0}};
    end else if (tlbp_we) begin
      idx_p_r <= ~tlbp_hit;
      idx_r   <= tlbp_hit ? tlbp_index : idx_r;
    end else if (wr_index_s) begin
      idx_p_r <= idx_p_r;
      idx_r   <= mtc0_data[IDX_W-1:0];
    end else begin
      idx_p_r <= idx_p_r;
      idx_r   <= idx_r;
    end
  end

  // Wired: software writable only
  always_ff @(posedge clk) begin
    if (reset) begin
      wired_r <= {IDX_W{1'b0}};
    end else if (wr_wired_s) begin
      wired_r <= mtc0_data[IDX_W-1:0];
    end else begin
      wired_r <= wired_r;
    end
  end

  // Random: counts down from the top entry to Wired, then reloads
  always_ff @(posedge clk) begin
    if (reset) begin
      random_r <= RAND_TOP;
    end else if (wr_wired_s) begin
      random_r <= RAND_TOP;
    end else if (wired_r >= RAND_TOP) begin
      random_r <= RAND_TOP;
    end else if ((random_r == wired_r) || (random_r == {IDX_W{1'b0}})) begin
      random_r <= RAND_TOP;
    end else begin
      random_r <= random_r - IDX_W'(1);
    end
  end

  // EntryHi: TLB exception loads VPN2 only, then TLBR, then software
  always_ff @(posedge clk) begin
    if (reset) begin
      vpn2_r <= 19'h0;
      asid_r <= 8'h0;
    end else if (exc_s && commit_tlb) begin
      vpn2_r <= commit_bvaddr[31:13];
      asid_r <= asid_r;
    end else if (tlbr_we) begin
      vpn2_r <= tlbr_entryhi[31:13];
      asid_r <= tlbr_entryhi[7:0];
    end else if (wr_entryhi_s) begin
      vpn2_r <= mtc0_data[31:13];
      asid_r <= mtc0_data[7:0];
    end else begin
      vpn2_r <= vpn2_r;
      asid_r <= asid_r;
    end
  end

  // EntryLo0/EntryLo1: TLBR wins over a software write
  always_ff @(posedge clk) begin
    if (reset) begin
      lo0_r <= 26'h0;
      lo1_r <= 26'h0;
    end else if (tlbr_we) begin
      lo0_r <= tlbr_entrylo0[25:0];
      lo1_r <= tlbr_entrylo1[25:0];
    end else begin
      lo0_r <= wr_entrylo0_s ? mtc0_data[25:0] : lo0_r;
      lo1_r <= wr_entrylo1_s ? mtc0_data[25:0] : lo1_r;
    end
  end

  assign index_rd_s    = {idx_p_r, {(31-IDX_W){1'b0}}, idx_r};
  assign random_rd_s   = {{(32-IDX_W){1'b0}}, random_r};
  assign wired_rd_s    = {{(32-IDX_W){1'b0}}, wired_r};
  assign entryhi_rd_s  = {vpn2_r, 5'b0, asid_r} & ENTRYHI_WMASK;
  assign entrylo0_rd_s = {6'b0, lo0_r};
  assign entrylo1_rd_s = {6'b0, lo1_r};
  assign config_val_s  = CONFIG_TLB;
  assign refill_s      = commit_refill & ~status_r[STATUS_EXL];
  assign index         = idx_r;
  assign random        = random_r;
`else
  logic unused_tlb_s;

  assign unused_tlb_s  = ^{tlbp_we, tlbp_hit, tlbp_index, tlbr_we, tlbr_entryhi,
                           tlbr_entrylo0, tlbr_entrylo1, commit_tlb, commit_refill};
  assign index_rd_s    = 32'h0;
  assign random_rd_s   = 32'h0;
  assign wired_rd_s    = 32'h0;
  assign entryhi_rd_s  = 32'h0;
  assign entrylo0_rd_s = 32'h0;
  assign entrylo1_rd_s = 32'h0;
  assign config_val_s  = CONFIG_NO_TLB;
  assign refill_s      = 1'b0;
  assign index         = {IDX_W{1'b0}};
  assign random        = {IDX_W{1'b0}};
`endif

  // Exception vector from pre-commit state; ERET returns to EPC
  logic [31:0] vec_base_s;
  logic [31:0] vec_off_s;
  logic [31:0] exc_vector_s;

  always_comb begin
    vec_base_s   = VEC_BASE_NORMAL;
    vec_off_s    = VEC_OFF_GENERAL;
    exc_vector_s = 32'h0;
    if (status_r[STATUS_BEV]) begin
      vec_base_s = VEC_BASE_BEV;
    end else begin
      vec_base_s = VEC_BASE_NORMAL;
    end
    if (refill_s) begin
      vec_off_s = VEC_OFF_REFILL;
    end else if ((commit_code == 5'd0) && iv_r) begin
      vec_off_s = VEC_OFF_INT;
    end else begin
      vec_off_s = VEC_OFF_GENERAL;
    end
    if (commit_eret) begin
      exc_vector_s = epc_r;
    end else begin
      exc_vector_s = vec_base_s + vec_off_s;
    end
  end

  // mfc0 read mux; unimplemented addresses read zero
  always_comb begin
    mfc0_data = 32'h0;
    case (addr)
      ADDR_INDEX:    mfc0_data = index_rd_s;
      ADDR_RANDOM:   mfc0_data = random_rd_s;
      ADDR_ENTRYLO0: mfc0_data = entrylo0_rd_s;
      ADDR_ENTRYLO1: mfc0_data = entrylo1_rd_s;
      ADDR_WIRED:    mfc0_data = wired_rd_s;
      ADDR_BADVADDR: mfc0_data = badvaddr_r;
      ADDR_COUNT:    mfc0_data = count_s;
      ADDR_ENTRYHI:  mfc0_data = entryhi_rd_s;
      ADDR_COMPARE:  mfc0_data = compare_s;
      ADDR_STATUS:   mfc0_data = status_r;
      ADDR_CAUSE:    mfc0_data = cause_s;
      ADDR_EPC:      mfc0_data = epc_r;
      ADDR_PRID:     mfc0_data = PRID;
      ADDR_CONFIG:   mfc0_data = config_val_s;
      default:       mfc0_data = 32'h0;
    endcase
  end

  assign int_sig = (|(ip_s & status_r[STATUS_IM_HI:STATUS_IM_LO])) & status_r[STATUS_IE]
                   & ~status_r[STATUS_EXL] & ~status_r[STATUS_ERL];

  assign exc_vector = exc_vector_s;
  assign status     = status_r;
  assign cause      = cause_s;
  assign epc        = epc_r;
  assign entryhi    = entryhi_rd_s;
  assign entrylo0   = entrylo0_rd_s;
  assign entrylo1   = entrylo1_rd_s;

endmodule

// File: tb/tb_cp0_regfile_v2.sv
// Directed self-checking bench for cp0_regfile_v2 (default parameters).
// Expected values for the TLB registers follow CP0_TLB_REGS_EN.
module tb_cp0_regfile_v2;
  import cp0_regfile_v2_pkg::*;

  localparam int IDX_W = 4;
`ifdef CP0_TLB_REGS_EN
  localparam bit TLB_EN = 1'b1;
`else
  localparam bit TLB_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       hw_int;
  logic             int_sig;
  logic             mtc0;
  logic [31:0]      mtc0_data;
  logic [7:0]       addr;
  logic [31:0]      mfc0_data;
  logic             commit_exc, commit_eret, commit_bd, commit_tlb, commit_refill;
  logic [4:0]       commit_code;
  logic [31:0]      commit_epc, commit_bvaddr;
  logic             tlbp_we, tlbp_hit, tlbr_we;
  logic [IDX_W-1:0] tlbp_index;
  logic [31:0]      tlbr_entryhi, tlbr_entrylo0, tlbr_entrylo1;
  logic [31:0]      exc_vector, status, cause, epc, entryhi, entrylo0, entrylo1;
  logic [IDX_W-1:0] index, random;

  int checks = 0;
  int errors = 0;

  cp0_regfile_v2 dut (
    .clk(clk), .reset(reset), .hw_int(hw_int), .int_sig(int_sig),
    .mtc0(mtc0), .mtc0_data(mtc0_data), .addr(addr), .mfc0_data(mfc0_data),
    .commit_exc(commit_exc), .commit_eret(commit_eret), .commit_code(commit_code),
    .commit_bd(commit_bd), .commit_epc(commit_epc), .commit_bvaddr(commit_bvaddr),
    .commit_tlb(commit_tlb), .commit_refill(commit_refill),
    .tlbp_we(tlbp_we), .tlbp_hit(tlbp_hit), .tlbp_index(tlbp_index),
    .tlbr_we(tlbr_we), .tlbr_entryhi(tlbr_entryhi), .tlbr_entrylo0(tlbr_entrylo0),
    .tlbr_entrylo1(tlbr_entrylo1), .exc_vector(exc_vector), .status(status),
    .cause(cause), .epc(epc), .entryhi(entryhi), .entrylo0(entrylo0),
    .entrylo1(entrylo1), .index(index), .random(random)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    mtc0 = 1'b1; addr = a; mtc0_data = d;
    @(negedge clk);
    mtc0 = 1'b0; mtc0_data = 32'h0;
  endtask

  task automatic clear_commit();
    commit_exc = 1'b0; commit_eret = 1'b0; commit_code = 5'd0; commit_bd = 1'b0;
    commit_epc = 32'h0; commit_bvaddr = 32'h0; commit_tlb = 1'b0; commit_refill = 1'b0;
    mtc0 = 1'b0; mtc0_data = 32'h0;
  endtask

  task automatic test_reset();
    logic [IDX_W-1:0] exp_rand;
    exp_rand = TLB_EN ? 4'd15 : 4'd0;
    reset = 1'b1; hw_int = 6'b0; addr = 8'h0;
    tlbp_we = 1'b0; tlbp_hit = 1'b0; tlbp_index = 4'd0;
    tlbr_we = 1'b0; tlbr_entryhi = 32'h0; tlbr_entrylo0 = 32'h0; tlbr_entrylo1 = 32'h0;
    clear_commit();
    repeat (3) @(negedge clk);
    addr = ADDR_STATUS; #1;
    checks++; if (mfc0_data !== 32'h0040_0002) begin errors++; $display("FAIL reset_status: got %h expected %h", mfc0_data, 32'h0040_0002); end
    checks++; if (cause !== 32'h0) begin errors++; $display("FAIL reset_cause: got %h expected %h", cause, 32'h0); end
    checks++; if (epc !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h expected %h", epc, 32'h0); end
    checks++; if (random !== exp_rand) begin errors++; $display("FAIL reset_random: got %0d expected %0d", random, exp_rand); end
    addr = ADDR_RANDOM; #1;
    checks++; if (mfc0_data !== {28'h0, exp_rand}) begin errors++; $display("FAIL reset_random_rd: got %h expected %h", mfc0_data, {28'h0, exp_rand}); end
    addr = ADDR_PRID; #1;
    checks++; if (mfc0_data !== 32'h0000_4220) begin errors++; $display("FAIL prid_rd: got %h expected %h", mfc0_data, 32'h0000_4220); end
    addr = 8'h88; #1;
    checks++; if (mfc0_data !== 32'h0) begin errors++; $display("FAIL unimpl_rd: got %h expected %h", mfc0_data, 32'h0); end
    checks++; if (int_sig !== 1'b0) begin errors++; $display("FAIL reset_int: got %b expected 0", int_sig); end
    commit_exc = 1'b1; #1;
    checks++; if (exc_vector !== 32'hBFC0_0380) begin errors++; $display("FAIL bev_vector: got %h expected %h", exc_vector, 32'hBFC0_0380); end
    commit_exc = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_timer();
    wr(ADDR_STATUS, 32'h0000_8001);
    wr(ADDR_COMPARE, 32'd5);
    wr(ADDR_COUNT, 32'd0);
    checks++; if (status !== 32'h0000_8001) begin errors++; $display("FAIL status_wr: got %h expected %h", status, 32'h0000_8001); end
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks++; if (cause[30] !== 1'b0) begin errors++; $display("FAIL ti_early cycle %0d: got %b expected 0", i, cause[30]); end
    end
    @(negedge clk);
    checks++; if (cause !== 32'h4000_8000) begin errors++; $display("FAIL ti_set: got %h expected %h", cause, 32'h4000_8000); end
    checks++; if (int_sig !== 1'b1) begin errors++; $display("FAIL timer_int: got %b expected 1", int_sig); end
    addr = ADDR_COUNT; #1;
    checks++; if (mfc0_data !== 32'd5) begin errors++; $display("FAIL count_rd: got %h expected %h", mfc0_data, 32'd5); end
    wr(ADDR_COMPARE, 32'hFFFF_0000);
    checks++; if (cause !== 32'h0) begin errors++; $display("FAIL ti_clear: got %h expected %h", cause, 32'h0); end
    checks++; if (int_sig !== 1'b0) begin errors++; $display("FAIL int_clear: got %b expected 0", int_sig); end
    hw_int = 6'b000001;
    @(negedge clk);
    checks++; if (cause !== 32'h0000_0400) begin errors++; $display("FAIL hw_ip2: got %h expected %h", cause, 32'h0000_0400); end
    checks++; if (int_sig !== 1'b0) begin errors++; $display("FAIL ip2_masked: got %b expected 0", int_sig); end
    hw_int = 6'b0;
    @(negedge clk);
  endtask

  task automatic test_exception();
    commit_exc = 1'b1; commit_code = 5'd4; commit_bd = 1'b1;
    commit_epc = 32'h8000_1004; commit_bvaddr = 32'hDEAD_BEEF;
    mtc0 = 1'b1; addr = ADDR_EPC; mtc0_data = 32'h0000_1234;
    #1;
    checks++; if (exc_vector !== 32'h8000_0180) begin errors++; $display("FAIL exc_vector: got %h expected %h", exc_vector, 32'h8000_0180); end
    @(negedge clk);
    clear_commit();
    checks++; if (epc !== 32'h8000_1004) begin errors++; $display("FAIL exc_epc: got %h expected %h", epc, 32'h8000_1004); end
    checks++; if (cause !== 32'h8000_0010) begin errors++; $display("FAIL exc_cause: got %h expected %h", cause, 32'h8000_0010); end
    checks++; if (status !== 32'h0000_8003) begin errors++; $display("FAIL exc_status: got %h expected %h", status, 32'h0000_8003); end
    addr = ADDR_BADVADDR; #1;
    checks++; if (mfc0_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL exc_badvaddr: got %h expected %h", mfc0_data, 32'hDEAD_BEEF); end
  endtask

  task automatic test_vectors();
    logic [31:0] exp_vec;
    logic [31:0] exp_ehi;
    wr(ADDR_CAUSE, 32'h0080_0000);
    checks++; if (cause !== 32'h8080_0010) begin errors++; $display("FAIL cause_wr: got %h expected %h", cause, 32'h8080_0010); end
    commit_exc = 1'b1; commit_code = 5'd0; commit_epc = 32'h8000_2000;
    #1;
    checks++; if (exc_vector !== 32'h8000_0200) begin errors++; $display("FAIL int_vector: got %h expected %h", exc_vector, 32'h8000_0200); end
    @(negedge clk);
    clear_commit();
    checks++; if (cause !== 32'h0080_0000) begin errors++; $display("FAIL int_cause: got %h expected %h", cause, 32'h0080_0000); end
    wr(ADDR_ENTRYHI, 32'h0000_00AA);
    wr(ADDR_STATUS, 32'h0000_8000);
    checks++; if (status !== 32'h0000_8000) begin errors++; $display("FAIL status_exl0: got %h expected %h", status, 32'h0000_8000); end
    commit_exc = 1'b1; commit_code = 5'd2; commit_tlb = 1'b1; commit_refill = 1'b1;
    commit_bvaddr = 32'h0040_2ABC; commit_epc = 32'h8000_3000;
    exp_vec = TLB_EN ? 32'h8000_0000 : 32'h8000_0180;
    exp_ehi = TLB_EN ? 32'h0040_20AA : 32'h0;
    #1;
    checks++; if (exc_vector !== exp_vec) begin errors++; $display("FAIL refill_vector: got %h expected %h", exc_vector, exp_vec); end
    @(negedge clk);
    clear_commit();
    checks++; if (entryhi !== exp_ehi) begin errors++; $display("FAIL refill_entryhi: got %h expected %h", entryhi, exp_ehi); end
    checks++; if (cause !== 32'h0080_0008) begin errors++; $display("FAIL refill_cause: got %h expected %h", cause, 32'h0080_0008); end
    checks++; if (status !== 32'h0000_8002) begin errors++; $display("FAIL refill_status: got %h expected %h", status, 32'h0000_8002); end
    addr = ADDR_BADVADDR; #1;
    checks++; if (mfc0_data !== 32'h0040_2ABC) begin errors++; $display("FAIL refill_badvaddr: got %h expected %h", mfc0_data, 32'h0040_2ABC); end
  endtask

  task automatic test_eret();
    commit_exc = 1'b1; commit_eret = 1'b1;
    mtc0 = 1'b1; addr = ADDR_STATUS; mtc0_data = 32'h1040_0000;
    #1;
    checks++; if (exc_vector !== 32'h8000_3000) begin errors++; $display("FAIL eret_vector: got %h expected %h", exc_vector, 32'h8000_3000); end
    @(negedge clk);
    clear_commit();
    checks++; if (status !== 32'h0000_8000) begin errors++; $display("FAIL eret_status: got %h expected %h", status, 32'h0000_8000); end
    checks++; if (epc !== 32'h8000_3000) begin errors++; $display("FAIL eret_epc: got %h expected %h", epc, 32'h8000_3000); end
    checks++; if (cause !== 32'h0080_0008) begin errors++; $display("FAIL eret_cause: got %h expected %h", cause, 32'h0080_0008); end
  endtask

  task automatic test_random();
    logic [IDX_W-1:0] exp_r;
    wr(ADDR_WIRED, 32'd4);
    exp_r = TLB_EN ? 4'd15 : 4'd0;
    checks++; if (random !== exp_r) begin errors++; $display("FAIL wired_reload: got %0d expected %0d", random, exp_r); end
    for (int k = 14; k >= 4; k--) begin
      @(negedge clk);
      exp_r = TLB_EN ? k[IDX_W-1:0] : 4'd0;
      checks++; if (random !== exp_r) begin errors++; $display("FAIL random_dec: got %0d expected %0d", random, exp_r); end
    end
    @(negedge clk);
    exp_r = TLB_EN ? 4'd15 : 4'd0;
    checks++; if (random !== exp_r) begin errors++; $display("FAIL random_wrap: got %0d expected %0d", random, exp_r); end
    addr = ADDR_WIRED; #1;
    checks++; if (mfc0_data !== (TLB_EN ? 32'd4 : 32'd0)) begin errors++; $display("FAIL wired_rd: got %h expected %h", mfc0_data, (TLB_EN ? 32'd4 : 32'd0)); end
  endtask

  task automatic test_tlb_regs();
    logic [31:0] exp_v;
    wr(ADDR_INDEX, 32'd3);
    tlbp_we = 1'b1; tlbp_hit = 1'b0; tlbp_index = 4'd9;
    @(negedge clk);
    tlbp_we = 1'b0;
    addr = ADDR_INDEX; #1;
    exp_v = TLB_EN ? 32'h8000_0003 : 32'h0;
    checks++; if (mfc0_data !== exp_v) begin errors++; $display("FAIL tlbp_miss: got %h expected %h", mfc0_data, exp_v); end
    tlbp_we = 1'b1; tlbp_hit = 1'b1; tlbp_index = 4'd7;
    @(negedge clk);
    tlbp_we = 1'b0; tlbp_hit = 1'b0;
    #1;
    exp_v = TLB_EN ? 32'h0000_0007 : 32'h0;
    checks++; if (mfc0_data !== exp_v) begin errors++; $display("FAIL tlbp_hit: got %h expected %h", mfc0_data, exp_v); end
    checks++; if (index !== exp_v[IDX_W-1:0]) begin errors++; $display("FAIL index_out: got %h expected %h", index, exp_v[IDX_W-1:0]); end
    tlbr_we = 1'b1; tlbr_entryhi = 32'hFFFF_FFFF; tlbr_entrylo0 = 32'hFFFF_FFFF; tlbr_entrylo1 = 32'h1234_5678;
    mtc0 = 1'b1; addr = ADDR_ENTRYLO1; mtc0_data = 32'h0;
    @(negedge clk);
    tlbr_we = 1'b0; mtc0 = 1'b0;
    exp_v = TLB_EN ? 32'hFFFF_E0FF : 32'h0;
    checks++; if (entryhi !== exp_v) begin errors++; $display("FAIL tlbr_entryhi: got %h expected %h", entryhi, exp_v); end
    exp_v = TLB_EN ? 32'h03FF_FFFF : 32'h0;
    checks++; if (entrylo0 !== exp_v) begin errors++; $display("FAIL tlbr_entrylo0: got %h expected %h", entrylo0, exp_v); end
    exp_v = TLB_EN ? 32'h0234_5678 : 32'h0;
    checks++; if (entrylo1 !== exp_v) begin errors++; $display("FAIL tlbr_entrylo1: got %h expected %h", entrylo1, exp_v); end
  endtask

  initial begin
    test_reset();
    test_timer();
    test_exception();
    test_vectors();
    test_eret();
    test_random();
    test_tlb_regs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
